// File: rtl/game_pkg.sv
// Shared types and constants for the grid memory-card game controller:
// state encoding, UART key codes, shuffle LFSR constants and width helpers.
package game_pkg;

    typedef enum logic [2:0] {
        ST_WAIT  = 3'd0,
        ST_SHOW  = 3'd1,
        ST_PICK1 = 3'd2,
        ST_PICK2 = 3'd3,
        ST_HOLD  = 3'd4,
        ST_END   = 3'd5
    } state_t;

    localparam logic [7:0] KEY_RESTART = 8'h30;
    localparam logic [7:0] KEY_UP      = 8'h31;
    localparam logic [7:0] KEY_DOWN    = 8'h32;
    localparam logic [7:0] KEY_LEFT    = 8'h33;
    localparam logic [7:0] KEY_RIGHT   = 8'h34;
    localparam logic [7:0] KEY_OPEN    = 8'h35;

    // x^16 + x^14 + x^13 + x^11 + 1, left-shifting Fibonacci form
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/game_tick_div.sv
// frame_tick prescaler: counts enabled ticks up to 'limit' and pulses tc on
// the last one; load clears the count and suppresses tc.
module game_tick_div #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic         tick,
    input  logic [W-1:0] limit,
    output logic         tc
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        tc    = en && tick && !load && (cnt_q == limit - W'(1));
        cnt_d = cnt_q;
        if (load || tc) begin
            cnt_d = '0;
        end else if (en && tick) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/game_ctrl_grid.sv
// Memory-card game controller for a ROWS x COLS grid: key decode, game flow,
// countdown and move counter. Define CARD_SHUFFLE_EN to rotate the layout per game.
module game_ctrl_grid
    import game_pkg::*;
#(
    parameter int unsigned ROWS            = 4,
    parameter int unsigned COLS            = 4,
    parameter int unsigned ID_W            = 4,
    parameter logic [ROWS*COLS*ID_W-1:0] INIT_CARD_LOC = 64'h0714_2061_4352_3657,
    parameter int unsigned FRAMES_PER_SEC  = 60,
    parameter int unsigned GAME_TIME       = 300,
    parameter int unsigned SHOW_SEC        = 5,
    parameter int unsigned MISMATCH_FRAMES = 45,
    localparam int unsigned N     = ROWS * COLS,
    localparam int unsigned IDX_W = idx_w(ROWS * COLS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_tick,
    input  logic [7:0]          rx_data,
    input  logic                rx_data_valid,
    output logic [2:0]          state,
    output logic [IDX_W-1:0]    cursor,
    output logic [IDX_W:0]      open_a,
    output logic [IDX_W:0]      open_b,
    output logic [N-1:0]        card_find,
    output logic [N*ID_W-1:0]   card_loc,
    output logic [11:0]         left_time,
    output logic [9:0]          move_cnt
);

    localparam int unsigned LOC_W       = N * ID_W;
    localparam int unsigned SHOW_FRAMES = SHOW_SEC * FRAMES_PER_SEC;
    localparam int unsigned FRM_MAX     = (SHOW_FRAMES > MISMATCH_FRAMES) ? SHOW_FRAMES : MISMATCH_FRAMES;
    localparam int unsigned FRM_W       = cnt_w(FRM_MAX);
    localparam int unsigned SEC_W       = cnt_w(FRAMES_PER_SEC);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    cursor_q, cursor_d;
    logic [IDX_W:0]      open_a_q, open_a_d, open_b_q, open_b_d;
    logic [N-1:0]        card_find_q, card_find_d;
    logic [LOC_W-1:0]    card_loc_q, card_loc_d;
    logic [11:0]         left_time_q, left_time_d;
    logic [9:0]          move_cnt_q, move_cnt_d;
    logic                rx_valid_q;

    logic                key_ev, in_play, end_cond, frm_run, sec_tc, frm_tc;
    logic [FRM_W-1:0]    frm_limit;
    logic [ID_W-1:0]     cur_id, a_id;
    logic [LOC_W-1:0]    layout;
    int unsigned         cur_i;

    assign key_ev    = rx_data_valid && !rx_valid_q;
    assign in_play   = (state_q == ST_PICK1) || (state_q == ST_PICK2) || (state_q == ST_HOLD);
    assign end_cond  = in_play && ((left_time_q == '0) || (&card_find_q));
    assign frm_run   = (state_q == ST_SHOW) || (state_q == ST_HOLD);
    assign frm_limit = (state_q == ST_SHOW) ? FRM_W'(SHOW_FRAMES) : FRM_W'(MISMATCH_FRAMES);
    assign cur_i     = 32'(cursor_q);
    assign cur_id    = card_loc_q[cur_i*ID_W +: ID_W];
    assign a_id      = card_loc_q[32'(open_a_q[IDX_W-1:0])*ID_W +: ID_W];

    // Seconds prescaler is held clear outside play, so each game starts on a full second.
    game_tick_div #(.W(SEC_W)) u_sec_div (
        .clk   (clk),
        .rst   (rst),
        .load  (!in_play),
        .en    (in_play),
        .tick  (frame_tick),
        .limit (SEC_W'(FRAMES_PER_SEC)),
        .tc    (sec_tc)
    );

    game_tick_div #(.W(FRM_W)) u_frm_div (
        .clk   (clk),
        .rst   (rst),
        .load  (!frm_run),
        .en    (frm_run),
        .tick  (frame_tick),
        .limit (frm_limit),
        .tc    (frm_tc)
    );

`ifdef CARD_SHUFFLE_EN
    logic [15:0]        lfsr_q;
    logic [2*LOC_W-1:0] rot_dbl;

    always_comb begin
        rot_dbl = {INIT_CARD_LOC, INIT_CARD_LOC} << ((32'(lfsr_q) % N) * ID_W);
        layout  = rot_dbl[2*LOC_W-1 -: LOC_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end
`else
    assign layout = INIT_CARD_LOC;
`endif

    always_comb begin
        state_d     = state_q;
        cursor_d    = cursor_q;
        open_a_d    = open_a_q;
        open_b_d    = open_b_q;
        card_find_d = card_find_q;
        card_loc_d  = card_loc_q;
        left_time_d = left_time_q;
        move_cnt_d  = move_cnt_q;

        if (sec_tc && (left_time_q != '0)) begin
            left_time_d = left_time_q - 12'd1;
        end

        case (state_q)
            ST_WAIT: begin
                if (key_ev && (rx_data == KEY_OPEN)) begin
                    state_d    = ST_SHOW;
                    card_loc_d = layout;
                end
            end
            ST_SHOW: begin
                if (frm_tc) begin
                    state_d = ST_PICK1;
                end
            end
            ST_PICK1, ST_PICK2: begin
                if (end_cond) begin
                    state_d = ST_END;
                end else if (key_ev) begin
                    case (rx_data)
                        KEY_UP:    if (cur_i >= COLS) cursor_d = IDX_W'(cur_i - COLS);
                        KEY_DOWN:  if (cur_i < N - COLS) cursor_d = IDX_W'(cur_i + COLS);
                        KEY_LEFT:  if ((cur_i % COLS) != 0) cursor_d = IDX_W'(cur_i - 1);
                        KEY_RIGHT: if ((cur_i % COLS) != COLS - 1) cursor_d = IDX_W'(cur_i + 1);
                        KEY_OPEN: begin
                            if (!card_find_q[cursor_q]) begin
                                if (state_q == ST_PICK1) begin
                                    open_a_d = {1'b1, cursor_q};
                                    state_d  = ST_PICK2;
                                end else if (cursor_q != open_a_q[IDX_W-1:0]) begin
                                    if (move_cnt_q != '1) begin
                                        move_cnt_d = move_cnt_q + 10'd1;
                                    end
                                    if (cur_id == a_id) begin
                                        card_find_d[cursor_q]              = 1'b1;
                                        card_find_d[open_a_q[IDX_W-1:0]]   = 1'b1;
                                        open_a_d                           = '0;
                                        open_b_d                           = '0;
                                        state_d                            = ST_PICK1;
                                    end else begin
                                        open_b_d = {1'b1, cursor_q};
                                        state_d  = ST_HOLD;
                                    end
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_HOLD: begin
                if (end_cond) begin
                    state_d = ST_END;
                end else if (frm_tc) begin
                    open_a_d = '0;
                    open_b_d = '0;
                    state_d  = ST_PICK1;
                end
            end
            default: ;
        endcase

        if (key_ev && (rx_data == KEY_RESTART) && (state_q != ST_WAIT) && !end_cond) begin
            state_d     = ST_WAIT;
            cursor_d    = '0;
            open_a_d    = '0;
            open_b_d    = '0;
            card_find_d = '0;
            move_cnt_d  = '0;
            left_time_d = 12'(GAME_TIME);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_WAIT;
            cursor_q    <= '0;
            open_a_q    <= '0;
            open_b_q    <= '0;
            card_find_q <= '0;
            card_loc_q  <= INIT_CARD_LOC;
            left_time_q <= 12'(GAME_TIME);
            move_cnt_q  <= '0;
            rx_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cursor_q    <= cursor_d;
            open_a_q    <= open_a_d;
            open_b_q    <= open_b_d;
            card_find_q <= card_find_d;
            card_loc_q  <= card_loc_d;
            left_time_q <= left_time_d;
            move_cnt_q  <= move_cnt_d;
            rx_valid_q  <= rx_data_valid;
        end
    end

    assign state     = state_q;
    assign cursor    = cursor_q;
    assign open_a    = open_a_q;
    assign open_b    = open_b_q;
    assign card_find = card_find_q;
    assign card_loc  = card_loc_q;
    assign left_time = left_time_q;
    assign move_cnt  = move_cnt_q;

endmodule

// File: tb/tb_game_ctrl_grid.sv
// Directed bench for game_ctrl_grid: default-parameter instance driven from a
// vector table, plus a short-timer instance for the time-out corner.
module tb_game_ctrl_grid;

    localparam logic [63:0] INIT_LOC = 64'h0714_2061_4352_3657;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_tick = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_data_valid = 1'b0;

    logic [2:0]  state, s2_state;
    logic [3:0]  cursor, s2_cursor;
    logic [4:0]  open_a, open_b, s2_open_a, s2_open_b;
    logic [15:0] card_find, s2_card_find;
    logic [63:0] card_loc, s2_card_loc;
    logic [11:0] left_time, s2_left_time;
    logic [9:0]  move_cnt, s2_move_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    game_ctrl_grid dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .rx_data(rx_data),
        .rx_data_valid(rx_data_valid), .state(state), .cursor(cursor),
        .open_a(open_a), .open_b(open_b), .card_find(card_find),
        .card_loc(card_loc), .left_time(left_time), .move_cnt(move_cnt)
    );

    game_ctrl_grid #(.GAME_TIME(2), .FRAMES_PER_SEC(2)) dut2 (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .rx_data(rx_data),
        .rx_data_valid(rx_data_valid), .state(s2_state), .cursor(s2_cursor),
        .open_a(s2_open_a), .open_b(s2_open_b), .card_find(s2_card_find),
        .card_loc(s2_card_loc), .left_time(s2_left_time), .move_cnt(s2_move_cnt)
    );

    typedef struct {
        logic [7:0]  key;
        int          ticks;
        logic [2:0]  st;
        logic [3:0]  cur;
        logic [4:0]  oa;
        logic [4:0]  ob;
        logic [15:0] find;
        logic [9:0]  mv;
        logic [11:0] lt;
    } vec_t;

    vec_t tbl[33];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_key(input logic [7:0] k);
        @(negedge clk);
        rx_data = k;
        rx_data_valid = 1'b1;
        @(negedge clk);
        rx_data_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            if (tbl[i].key != 8'h00) send_key(tbl[i].key);
            ticks(tbl[i].ticks);
            idle(2);
            check($sformatf("v%0d_state", i), 64'(state), 64'(tbl[i].st));
            check($sformatf("v%0d_cursor", i), 64'(cursor), 64'(tbl[i].cur));
            check($sformatf("v%0d_open_a", i), 64'(open_a), 64'(tbl[i].oa));
            check($sformatf("v%0d_open_b", i), 64'(open_b), 64'(tbl[i].ob));
            check($sformatf("v%0d_card_find", i), 64'(card_find), 64'(tbl[i].find));
            check($sformatf("v%0d_move_cnt", i), 64'(move_cnt), 64'(tbl[i].mv));
            check($sformatf("v%0d_left_time", i), 64'(left_time), 64'(tbl[i].lt));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1);
    end

    initial begin
        //           key    ticks st  cur  oa     ob     find      mv  lt
        tbl[0]  = '{8'h00, 0,   0, 0,  5'h00, 5'h00, 16'h0000, 0, 300};
        tbl[1]  = '{8'h35, 0,   1, 0,  5'h00, 5'h00, 16'h0000, 0, 300};
        tbl[2]  = '{8'h00, 299, 1, 0,  5'h00, 5'h00, 16'h0000, 0, 300};
        tbl[3]  = '{8'h00, 1,   2, 0,  5'h00, 5'h00, 16'h0000, 0, 300};
        tbl[4]  = '{8'h35, 0,   3, 0,  5'h10, 5'h00, 16'h0000, 0, 300};
        tbl[5]  = '{8'h34, 0,   3, 1,  5'h10, 5'h00, 16'h0000, 0, 300};
        tbl[6]  = '{8'h35, 0,   4, 1,  5'h10, 5'h11, 16'h0000, 1, 300};
        tbl[7]  = '{8'h00, 44,  4, 1,  5'h10, 5'h11, 16'h0000, 1, 300};
        tbl[8]  = '{8'h00, 1,   2, 1,  5'h00, 5'h00, 16'h0000, 1, 300};
        tbl[9]  = '{8'h30, 0,   0, 0,  5'h00, 5'h00, 16'h0000, 0, 300};
        tbl[10] = '{8'h35, 0,   1, 0,  5'h00, 5'h00, 16'h0000, 0, 300};
        tbl[11] = '{8'h00, 300, 2, 0,  5'h00, 5'h00, 16'h0000, 0, 300};
        tbl[12] = '{8'h31, 0,   2, 0,  5'h00, 5'h00, 16'h0000, 0, 300};
        tbl[13] = '{8'h33, 0,   2, 0,  5'h00, 5'h00, 16'h0000, 0, 300};
        tbl[14] = '{8'h35, 0,   3, 0,  5'h10, 5'h00, 16'h0000, 0, 300};
        tbl[15] = '{8'h35, 0,   3, 0,  5'h10, 5'h00, 16'h0000, 0, 300};
        tbl[16] = '{8'h32, 0,   3, 4,  5'h10, 5'h00, 16'h0000, 0, 300};
        tbl[17] = '{8'h32, 0,   3, 8,  5'h10, 5'h00, 16'h0000, 0, 300};
        tbl[18] = '{8'h32, 0,   3, 12, 5'h10, 5'h00, 16'h0000, 0, 300};
        tbl[19] = '{8'h34, 0,   3, 13, 5'h10, 5'h00, 16'h0000, 0, 300};
        tbl[20] = '{8'h34, 0,   3, 14, 5'h10, 5'h00, 16'h0000, 0, 300};
        tbl[21] = '{8'h35, 0,   2, 14, 5'h00, 5'h00, 16'h4001, 1, 300};
        tbl[22] = '{8'h34, 0,   2, 14, 5'h00, 5'h00, 16'h4001, 1, 300};
        tbl[23] = '{8'h34, 0,   2, 15, 5'h00, 5'h00, 16'h4001, 1, 300};
        tbl[24] = '{8'h32, 0,   2, 15, 5'h00, 5'h00, 16'h4001, 1, 300};
        tbl[25] = '{8'h34, 0,   2, 15, 5'h00, 5'h00, 16'h4001, 1, 300};
        tbl[26] = '{8'h33, 0,   2, 14, 5'h00, 5'h00, 16'h4001, 1, 300};
        tbl[27] = '{8'h35, 0,   2, 14, 5'h00, 5'h00, 16'h4001, 1, 300};
        tbl[28] = '{8'h00, 59,  2, 14, 5'h00, 5'h00, 16'h4001, 1, 300};
        tbl[29] = '{8'h00, 1,   2, 14, 5'h00, 5'h00, 16'h4001, 1, 299};
        tbl[30] = '{8'h35, 0,   3, 13, 5'h1D, 5'h00, 16'h4001, 1, 298};
        tbl[31] = '{8'h33, 0,   3, 12, 5'h1D, 5'h00, 16'h4001, 1, 298};
        tbl[32] = '{8'h35, 0,   4, 12, 5'h1D, 5'h1C, 16'h4001, 2, 298};

        idle(3);
        rst = 1'b0;
        idle(1);
        check("reset_card_loc", card_loc, INIT_LOC);

        apply_range(0, 21);

        // A held valid level must produce exactly one cursor move.
        @(negedge clk);
        rx_data = 8'h33;
        rx_data_valid = 1'b1;
        idle(3);
        rx_data_valid = 1'b0;
        idle(2);
        check("held_key_cursor", 64'(cursor), 64'd13);

        apply_range(22, 29);

        // Key and frame_tick in the same cycle, tick landing on a second boundary.
        ticks(59);
        @(negedge clk);
        rx_data = 8'h33;
        rx_data_valid = 1'b1;
        frame_tick = 1'b1;
        @(negedge clk);
        rx_data_valid = 1'b0;
        frame_tick = 1'b0;
        idle(2);
        check("simul_cursor", 64'(cursor), 64'd13);
        check("simul_left_time", 64'(left_time), 64'd298);
        check("show_card_loc", card_loc, INIT_LOC);

        apply_range(30, 32);

        // Asynchronous reset while in HOLD, observed before the next clock edge.
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_state", 64'(state), 64'd0);
        check("arst_cursor", 64'(cursor), 64'd0);
        check("arst_open_a", 64'(open_a), 64'd0);
        check("arst_open_b", 64'(open_b), 64'd0);
        check("arst_card_find", 64'(card_find), 64'd0);
        check("arst_move_cnt", 64'(move_cnt), 64'd0);
        check("arst_left_time", 64'(left_time), 64'd300);
        check("arst_card_loc", card_loc, INIT_LOC);
        @(negedge clk);
        rst = 1'b0;
        idle(1);

        // Short-timer instance: 2 s game at 2 frames per second.
        send_key(8'h35);
        idle(1);
        check("t2_show", 64'(s2_state), 64'd1);
        ticks(10);
        idle(2);
        check("t2_pick_state", 64'(s2_state), 64'd2);
        check("t2_pick_time", 64'(s2_left_time), 64'd2);
        ticks(3);
        idle(2);
        check("t2_mid_state", 64'(s2_state), 64'd2);
        check("t2_mid_time", 64'(s2_left_time), 64'd1);
        ticks(1);
        idle(2);
        check("t2_end_time", 64'(s2_left_time), 64'd0);
        check("t2_end_state", 64'(s2_state), 64'd5);
        send_key(8'h35);
        idle(1);
        check("t2_end_open_ignored", 64'(s2_state), 64'd5);
        send_key(8'h30);
        idle(1);
        check("t2_restart_state", 64'(s2_state), 64'd0);
        check("t2_restart_time", 64'(s2_left_time), 64'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/game_ctrl_grid.md
Name: game_ctrl_grid

Overview:
- Parametrised successor of the memory-card game controller for an arbitrary ROWS x COLS grid.
- Decodes UART key bytes into cursor moves, card opens and restart.
- Runs the WAIT/SHOW/PICK/HOLD/END game flow and keeps a frame-tick-driven countdown.
- Adds a timed mismatch reveal, a move counter and restart without reset; feeds the VGA/HDMI card renderer.

Parameters:
- ROWS, 4, grid rows.
- COLS, 4, grid columns; N = ROWS*COLS, must be even, at most 64.
- ID_W, 4, bits per card id. Ids 0..N/2-1 each appear exactly twice.
- INIT_CARD_LOC, 64'h0714_2061_4352_3657, packed N*ID_W layout. Slot k is bits [k*ID_W +: ID_W].
- FRAMES_PER_SEC, 60, frame_tick pulses per second.
- GAME_TIME, 300, countdown start value in seconds.
- SHOW_SEC, 5, memorise period in seconds.
- MISMATCH_FRAMES, 45, frames a wrong pair stays revealed.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-clk pulse per video frame, synchronous to clk
- rx_data  in  8  UART byte
- rx_data_valid  in  1  level; a key is accepted on its rising edge only
- state  out  3  WAIT=0, SHOW=1, PICK1=2, PICK2=3, HOLD=4, END=5
- cursor  out  IDX_W  selected slot, where IDX_W = clog2(N)
- open_a  out  IDX_W+1  MSB = valid, LSBs = first opened slot
- open_b  out  IDX_W+1  MSB = valid, LSBs = second opened slot
- card_find  out  N  bit k set when slot k is matched
- card_loc  out  N*ID_W  current layout
- left_time  out  12  seconds remaining
- move_cnt  out  10  completed pair attempts

Behaviour:
- Reset values:
  - state=WAIT, cursor=0, open_a=0, open_b=0, card_find=0.
  - card_loc=INIT_CARD_LOC, left_time=GAME_TIME, move_cnt=0.
  - All internal counters are 0. Reset mid-game aborts everything immediately.
- Key edge: key_ev is asserted when rx_data_valid=1 and its value on the previous clk was 0. Only one event per edge.
- Key codes:
  - 0x31 up, 0x32 down, 0x33 left, 0x34 right.
  - 0x35 open/start, 0x30 restart. All other bytes are ignored.
- Cursor moves apply only in PICK1 and PICK2, and are saturating:
  - up when cursor>=COLS: cursor-COLS.
  - down when cursor<N-COLS: cursor+COLS.
  - left when cursor%COLS!=0: cursor-1.
  - right when cursor%COLS!=COLS-1: cursor+1.
- WAIT:
  - left_time and move_cnt are held at reset values; card_find=0.
  - On 0x35, go to SHOW and latch the layout (see Optional Feature).
- SHOW:
  - The renderer shows all faces.
  - After SHOW_SEC*FPS frame_ticks, go to PICK1.
  - left_time is frozen during SHOW.
- PICK1: on 0x35 at an unmatched cursor, load open_a={1,cursor} and go to PICK2. An already-found slot is ignored.
- PICK2: on 0x35 at an unmatched cursor != open_a index, load open_b={1,cursor} and increment move_cnt (saturating at 1023).
  - Ids equal: set both card_find bits in the same cycle, clear open_a and open_b, go to PICK1.
  - Ids differ: go to HOLD.
- HOLD:
  - Keys are ignored.
  - After MISMATCH_FRAMES frame_ticks, clear open_a and open_b and go to PICK1.
- Timer:
  - In PICK1, PICK2 and HOLD, a prescaler counts frame_ticks; left_time decrements every FRAMES_PER_SEC ticks and saturates at 0.
  - The prescaler clears on entry to PICK1 from SHOW.
- END conditions, from PICK1, PICK2 or HOLD:
  - If left_time==0 or card_find is all-ones, go to END on the next clk.
  - This has priority over a key event in the same cycle.
  - The open_a and open_b values are kept in END.
- END: all keys are ignored except 0x30.
- Restart: 0x30 in any state except WAIT returns to WAIT, clears open_a, open_b, card_find, move_cnt and cursor, and reloads left_time.
- Simultaneous key_ev and frame_tick: both are processed in the same cycle.

Optional Feature:
- Macro: CARD_SHUFFLE_EN.
- When defined:
  - A 16-bit maximal LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1) free-runs from reset.
  - On the WAIT->SHOW transition, card_loc = INIT_CARD_LOC rotated left by (lfsr % N) slots, i.e. by ID_W*r bits.
- When undefined: card_loc = INIT_CARD_LOC, and no LFSR is instantiated.

Decomposition:
- Package game_pkg:
  - State enum.
  - Key-code localparams KEY_UP..KEY_RESTART.
  - LFSR seed and taps.
  - clog2-derived width helpers.
- Sub-module game_tick_div: a frame_tick prescaler with load/enable and a terminal-count pulse, instantiated twice (seconds and hold frames).

Test Plan:
Defaults throughout, shuffle off. Slot ids from LSB: 7,5,6,3,2,5,3,4,1,6,0,2,4,1,7,0.
1. 0x35 in WAIT -> state 1; after 300 frame_ticks -> state 2, left_time=300.
2. Open slot 0, then 3x down and 2x right, open -> cursor=14, card_find=16'h4001, move_cnt=1, state 2.
3. Open slot 0, right, open slot 1 -> state 4 with open_a=5'h10 and open_b=5'h11. After 45 ticks -> open_a=0 and open_b=0, state 2, card_find unchanged.
4. Cursor 0 with up and left -> stays 0. Cursor 15 with down and right -> stays 15. Re-opening slot 0 as the second card -> ignored.
5. GAME_TIME=2, FRAMES_PER_SEC=2, in PICK1: 4 frame_ticks -> left_time=0, state 5. Then 0x35 -> still 5. Then 0x30 -> state 0, left_time=2.
6. Assert rst during HOLD -> all outputs return to reset values asynchronously.
